// File: rtl/updown_counter_param.sv
// updown_counter_param: parameterised up/down counter with synchronous
// clear, saturating parallel load, combinational terminal-count and zero
// flags, and a registered one-cycle overflow pulse.
//
// Build option: define UDC_SAT_EN to make the counter saturate at its
// bounds instead of wrapping. In saturating mode the overflow pulse marks
// each blocked step rather than a wrap.
//
// The counter runs modulo (MAX+1). Bound detection compares against MAX
// and zero explicitly, so it never relies on the register rolling over.
module updown_counter_param #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             zero
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] countQ, countD;
  logic             ovfQ, ovfD;
  logic             atMax, atZero;

  assign atMax  = (countQ >= MAX);
  assign atZero = (countQ == ZERO);

  // Next-state selection with priority clear > load > count step.
  // The overflow pulse is raised only by a step that hits a bound.
  always_comb begin
    countD = countQ;
    ovfD   = 1'b0;
    if (clr) begin
      countD = ZERO;
    end else if (load) begin
      countD = (din > MAX) ? MAX : din;
    end else if (en) begin
      if (!mode) begin
        if (atMax) begin
`ifdef UDC_SAT_EN
          countD = MAX;
`else
          countD = ZERO;
`endif
          ovfD   = 1'b1;
        end else begin
          countD = countQ + ONE;
        end
      end else begin
        if (atZero) begin
`ifdef UDC_SAT_EN
          countD = ZERO;
`else
          countD = MAX;
`endif
          ovfD   = 1'b1;
        end else begin
          countD = countQ - ONE;
        end
      end
    end
  end

  // State register; reset clears the count and any pending overflow pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      countQ <= ZERO;
      ovfQ   <= 1'b0;
    end else begin
      countQ <= countD;
      ovfQ   <= ovfD;
    end
  end

  // Terminal count looks at the bound in the currently selected direction.
  assign tc    = en & (mode ? atZero : atMax);
  assign zero  = atZero;
  assign count = countQ;
  assign ovf   = ovfQ;

endmodule
